wb_regfile: RTL and testbench

- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value from ALU result, load data, immediate, PC+imm or PC+4.
- Commits that value to the 32-entry integer register file and serves the two decode-stage read ports.
- Keeps a retired-write counter and a registered copy of the last committed write, for debug and bench checking.

---
 rtl/wb_regfile.sv | 96 +++++++++
 tb/tb_wb_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, 32-entry integer register file, retired-write debug state
//
// Optional build macro: WB_BYPASS_EN
//   defined   -> a read port whose address matches a committing Rd returns wb_data_o
//                in the same cycle (write-through)
//   undefined -> read ports return the pre-edge array contents
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   *_wb_i              MEM/WB pipeline outputs (data candidates, Rd, control bits)
//   Rs1/Rs2_addr_i      decode-stage read addresses
//   Rs1/Rs2_data_o      combinational read data (x0 reads 0)
//   wb_data_o           selected writeback value
//   wb_count_o          committed-write counter (wraps)
//   last_rd_o/last_data_o  Rd and data of the most recent committed write
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ALU_result_wb_i,
    input  logic [DATA_W-1:0] pc_jump_wb_i,
    input  logic [DATA_W-1:0] loaddata_wb_i,
    input  logic [DATA_W-1:0] imme_wb_i,
    input  logic [DATA_W-1:0] pc_order_wb_i,
    input  logic [ADDR_W-1:0] Rd_wb_i,
    input  logic              jal_wb_i,
    input  logic              jalr_wb_i,
    input  logic              lui_wb_i,
    input  logic              U_type_wb_i,
    input  logic              MemtoReg_wb_i,
    input  logic              RegWrite_wb_i,
    input  logic [ADDR_W-1:0] Rs1_addr_i,
    input  logic [ADDR_W-1:0] Rs2_addr_i,
    output logic [DATA_W-1:0] Rs1_data_o,
    output logic [DATA_W-1:0] Rs2_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [CNT_W-1:0]  wb_count_o,
    output logic [ADDR_W-1:0] last_rd_o,
    output logic [DATA_W-1:0] last_data_o
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [CNT_W-1:0]  wb_count_q, wb_count_d;
    logic [ADDR_W-1:0] last_rd_q, last_rd_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic              commit;

    // Jumps link PC+4 ahead of every other source; lui beats auipc beats loads.
    always_comb begin
        wb_data_o = (jal_wb_i | jalr_wb_i) ? pc_order_wb_i :
                    lui_wb_i               ? imme_wb_i     :
                    U_type_wb_i            ? pc_jump_wb_i  :
                    MemtoReg_wb_i          ? loaddata_wb_i :
                                             ALU_result_wb_i;
        commit      = RegWrite_wb_i && (Rd_wb_i != '0);
        wb_count_d  = commit ? wb_count_q + CNT_W'(1) : wb_count_q;
        last_rd_d   = commit ? Rd_wb_i : last_rd_q;
        last_data_d = commit ? wb_data_o : last_data_q;
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        Rs1_data_o = (Rs1_addr_i == '0) ? '0 :
                     (commit && Rs1_addr_i == Rd_wb_i) ? wb_data_o : rf_q[Rs1_addr_i];
        Rs2_data_o = (Rs2_addr_i == '0) ? '0 :
                     (commit && Rs2_addr_i == Rd_wb_i) ? wb_data_o : rf_q[Rs2_addr_i];
    end
`else
    always_comb begin
        Rs1_data_o = (Rs1_addr_i == '0) ? '0 : rf_q[Rs1_addr_i];
        Rs2_data_o = (Rs2_addr_i == '0) ? '0 : rf_q[Rs2_addr_i];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            wb_count_q  <= '0;
            last_rd_q   <= '0;
            last_data_q <= '0;
        end else begin
            if (commit) rf_q[Rd_wb_i] <= wb_data_o;
            wb_count_q  <= wb_count_d;
            last_rd_q   <= last_rd_d;
            last_data_q <= last_data_d;
        end
    end

    assign wb_count_o  = wb_count_q;
    assign last_rd_o   = last_rd_q;
    assign last_data_o = last_data_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a register-array model
module tb_wb_regfile;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] alu = 0, pcj = 0, ld = 0, imm = 0, pco = 0;
    logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
    logic        jal = 0, jalr = 0, lui = 0, ut = 0, m2r = 0, rw = 0;
    logic [31:0] rs1_data, rs2_data, wb_data, wb_count, last_data;
    logic [4:0]  last_rd;

    logic [31:0] m_rf [32];
    logic [31:0] m_cnt, m_last_data;
    logic [4:0]  m_last_rd;
    int          n_checks = 0;
    int          n_fail = 0;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .ALU_result_wb_i(alu), .pc_jump_wb_i(pcj), .loaddata_wb_i(ld),
        .imme_wb_i(imm), .pc_order_wb_i(pco), .Rd_wb_i(rd),
        .jal_wb_i(jal), .jalr_wb_i(jalr), .lui_wb_i(lui), .U_type_wb_i(ut),
        .MemtoReg_wb_i(m2r), .RegWrite_wb_i(rw),
        .Rs1_addr_i(rs1), .Rs2_addr_i(rs2),
        .Rs1_data_o(rs1_data), .Rs2_data_o(rs2_data), .wb_data_o(wb_data),
        .wb_count_o(wb_count), .last_rd_o(last_rd), .last_data_o(last_data)
    );

    always #5 clk = ~clk;

    // Writeback value chosen by the priority list: link, lui, auipc, load, ALU.
    function automatic logic [31:0] exp_wb();
        if (jal || jalr) return pco;
        if (lui) return imm;
        if (ut) return pcj;
        if (m2r) return ld;
        return alu;
    endfunction

    function automatic logic will_commit();
        return rw && rd != 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 0;
`ifdef WB_BYPASS_EN
        if (will_commit() && a == rd) return exp_wb();
`endif
        return m_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        m_cnt = 0; m_last_rd = 0; m_last_data = 0;
    endtask

    task automatic idle();
        rw = 0; jal = 0; jalr = 0; lui = 0; ut = 0; m2r = 0; rd = 0;
    endtask

    // One clock edge; the model commits exactly what was presented before it.
    task automatic step();
        logic        c;
        logic [31:0] v;
        c = will_commit();
        v = exp_wb();
        @(posedge clk);
        if (rst_n && c) begin
            m_rf[rd] = v; m_cnt = m_cnt + 1; m_last_rd = rd; m_last_data = v;
        end
        #1;
    endtask

    task automatic write_alu(input logic [4:0] r, input logic [31:0] d);
        idle(); rw = 1; rd = r; alu = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); model_reset();
        rs1 = 5; rs2 = 31;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        #1;
        n_checks++; if (rs1_data !== 0) begin n_fail++; $display("FAIL reset_rs1 got=%h exp=0", rs1_data); end
        n_checks++; if (rs2_data !== 0) begin n_fail++; $display("FAIL reset_rs2 got=%h exp=0", rs2_data); end
        n_checks++; if (wb_count !== 0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
        n_checks++; if (last_rd !== 0) begin n_fail++; $display("FAIL reset_last_rd got=%0d exp=0", last_rd); end
        n_checks++; if (last_data !== 0) begin n_fail++; $display("FAIL reset_last_data got=%h exp=0", last_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_write();
        write_alu(3, 32'h1234);
        rs1 = 3; #1;
        n_checks++; if (rs1_data !== 32'h1234) begin n_fail++; $display("FAIL basic_x3 got=%h exp=00001234", rs1_data); end
        n_checks++; if (wb_count !== 1) begin n_fail++; $display("FAIL basic_count got=%0d exp=1", wb_count); end
        n_checks++; if (last_rd !== 3) begin n_fail++; $display("FAIL basic_last_rd got=%0d exp=3", last_rd); end
        n_checks++; if (last_data !== 32'h1234) begin n_fail++; $display("FAIL basic_last_data got=%h exp=00001234", last_data); end
    endtask

    task automatic test_priority();
        idle(); rw = 1; jal = 1; lui = 1; m2r = 1;
        pco = 32'h104; imm = 32'hABCD0000; ld = 32'h55; rd = 1; #1;
        n_checks++; if (wb_data !== 32'h104) begin n_fail++; $display("FAIL prio_jal_wb got=%h exp=00000104", wb_data); end
        step();
        jal = 0; rd = 2; #1;
        n_checks++; if (wb_data !== 32'hABCD0000) begin n_fail++; $display("FAIL prio_lui_wb got=%h exp=abcd0000", wb_data); end
        step();
        lui = 0; ut = 1; pcj = 32'h2000; rd = 4;
        step();
        idle(); jalr = 1; ut = 1; rd = 0; #1;
        n_checks++; if (wb_data !== 32'h104) begin n_fail++; $display("FAIL prio_jalr_wb got=%h exp=00000104", wb_data); end
        idle(); rs1 = 1; rs2 = 2; #1;
        n_checks++; if (rs1_data !== 32'h104) begin n_fail++; $display("FAIL prio_x1 got=%h exp=00000104", rs1_data); end
        n_checks++; if (rs2_data !== 32'hABCD0000) begin n_fail++; $display("FAIL prio_x2 got=%h exp=abcd0000", rs2_data); end
        rs1 = 4; rs2 = 4; #1;
        n_checks++; if (rs1_data !== 32'h2000) begin n_fail++; $display("FAIL prio_x4_rs1 got=%h exp=00002000", rs1_data); end
        n_checks++; if (rs2_data !== 32'h2000) begin n_fail++; $display("FAIL prio_x4_rs2 got=%h exp=00002000", rs2_data); end
        n_checks++; if (wb_count !== 4) begin n_fail++; $display("FAIL prio_count got=%0d exp=4", wb_count); end
    endtask

    task automatic test_x0_write();
        write_alu(0, 32'hFFFFFFFF);
        rs1 = 0; #1;
        n_checks++; if (rs1_data !== 0) begin n_fail++; $display("FAIL x0_read got=%h exp=0", rs1_data); end
        n_checks++; if (wb_count !== 4) begin n_fail++; $display("FAIL x0_count got=%0d exp=4", wb_count); end
        n_checks++; if (last_rd !== 4) begin n_fail++; $display("FAIL x0_last_rd got=%0d exp=4", last_rd); end
        n_checks++; if (last_data !== 32'h2000) begin n_fail++; $display("FAIL x0_last_data got=%h exp=00002000", last_data); end
    endtask

    task automatic test_bypass();
        logic [31:0] pre;
        write_alu(7, 32'h11);
`ifdef WB_BYPASS_EN
        pre = 32'h99;
`else
        pre = 32'h11;
`endif
        idle(); rw = 1; rd = 7; ld = 32'h99; m2r = 1; rs1 = 7; rs2 = 0; #1;
        n_checks++; if (rs1_data !== pre) begin n_fail++; $display("FAIL bypass_pre got=%h exp=%h", rs1_data, pre); end
        n_checks++; if (rs2_data !== 0) begin n_fail++; $display("FAIL bypass_x0 got=%h exp=0", rs2_data); end
        step();
        idle(); #1;
        n_checks++; if (rs1_data !== 32'h99) begin n_fail++; $display("FAIL bypass_post got=%h exp=00000099", rs1_data); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rw = ($urandom_range(0, 3) != 0);
            jal = ($urandom_range(0, 5) == 0); jalr = ($urandom_range(0, 5) == 0);
            lui = ($urandom_range(0, 4) == 0); ut = ($urandom_range(0, 4) == 0);
            m2r = ($urandom_range(0, 2) == 0);
            alu = $urandom; pcj = $urandom; ld = $urandom; imm = $urandom; pco = $urandom;
            rd = 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            #1;
            n_checks++; if (wb_data !== exp_wb()) begin n_fail++; $display("FAIL rand_wb[%0d] got=%h exp=%h", n, wb_data, exp_wb()); end
            n_checks++; if (rs1_data !== exp_rd(rs1)) begin n_fail++; $display("FAIL rand_rs1[%0d] x%0d got=%h exp=%h", n, rs1, rs1_data, exp_rd(rs1)); end
            n_checks++; if (rs2_data !== exp_rd(rs2)) begin n_fail++; $display("FAIL rand_rs2[%0d] x%0d got=%h exp=%h", n, rs2, rs2_data, exp_rd(rs2)); end
            step();
            n_checks++; if (wb_count !== m_cnt) begin n_fail++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, wb_count, m_cnt); end
            n_checks++; if (last_rd !== m_last_rd) begin n_fail++; $display("FAIL rand_last_rd[%0d] got=%0d exp=%0d", n, last_rd, m_last_rd); end
            n_checks++; if (last_data !== m_last_data) begin n_fail++; $display("FAIL rand_last_data[%0d] got=%h exp=%h", n, last_data, m_last_data); end
        end
        idle();
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a); rs2 = 5'(31 - a); #1;
            n_checks++; if (rs1_data !== exp_rd(rs1)) begin n_fail++; $display("FAIL sweep_rs1 x%0d got=%h exp=%h", a, rs1_data, exp_rd(rs1)); end
            n_checks++; if (rs2_data !== exp_rd(rs2)) begin n_fail++; $display("FAIL sweep_rs2 x%0d got=%h exp=%h", 31 - a, rs2_data, exp_rd(rs2)); end
        end
    endtask

    task automatic test_async_reset();
        write_alu(9, 32'h77);
        rs1 = 9; #1;
        n_checks++; if (rs1_data !== 32'h77) begin n_fail++; $display("FAIL areset_pre got=%h exp=00000077", rs1_data); end
        // Hold a write in flight across an edge while reset is asserted.
        idle(); rw = 1; rd = 10; alu = 32'hDEAD; rs2 = 10;
        #2 rst_n = 0;
        #1;
        n_checks++; if (rs1_data !== 0) begin n_fail++; $display("FAIL areset_x9 got=%h exp=0", rs1_data); end
        n_checks++; if (wb_count !== 0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", wb_count); end
        n_checks++; if (last_rd !== 0) begin n_fail++; $display("FAIL areset_last_rd got=%0d exp=0", last_rd); end
        n_checks++; if (last_data !== 0) begin n_fail++; $display("FAIL areset_last_data got=%h exp=0", last_data); end
        model_reset();
        @(posedge clk); #1;
        idle(); #1;
        n_checks++; if (rs2_data !== 0) begin n_fail++; $display("FAIL areset_discard got=%h exp=0", rs2_data); end
        n_checks++; if (wb_count !== 0) begin n_fail++; $display("FAIL areset_discard_count got=%0d exp=0", wb_count); end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        write_alu(12, 32'hCAFE);
        rs1 = 12; #1;
        n_checks++; if (rs1_data !== 32'hCAFE) begin n_fail++; $display("FAIL post_reset_x12 got=%h exp=0000cafe", rs1_data); end
        n_checks++; if (wb_count !== 1) begin n_fail++; $display("FAIL post_reset_count got=%0d exp=1", wb_count); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_priority();
        test_x0_write();
        test_bypass();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
